fft_peak_detect: RTL and testbench

- Downstream consumer of the FFT address controller's output phase.
- While fft_done is high, the controller steps the RAM read address 0,1,2,… one bin per cycle. This block takes the real/imag read data, computes squared magnitude per bin, and finds the strongest bin in the positive-frequency half (excluding DC).
- Produces a one-cycle peak_valid pulse with peak bin, magnitude and a threshold-qualified note_present flag for the note-mapping stage.

---
 rtl/fft_peak_detect_pkg.sv | 17 +
 rtl/fft_peak_detect_mag_sq.sv | 51 +++++
 rtl/fft_peak_detect.sv | 189 ++++++++++++++++++
 tb/tb_fft_peak_detect.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_peak_detect_pkg.sv
// Shared FFT definitions: sample/magnitude widths, magnitude type and peak-detector FSM states.
package fft_peak_detect_pkg;

    localparam int SAMPLE_W = 16;
    localparam int MAG_W    = 2 * SAMPLE_W;

    typedef logic [MAG_W-1:0] mag_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        WAIT  = 3'd4
    } state_t;

endpackage

// File: rtl/fft_peak_detect_mag_sq.sv
// mag_sq: two-stage registered re^2 + im^2 with valid/tag passthrough and synchronous flush.
module mag_sq #(
    parameter int BIT_WIDTH = 16,
    parameter int TAG_W     = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic [TAG_W-1:0]            in_tag,
    input  logic signed [BIT_WIDTH-1:0] re,
    input  logic signed [BIT_WIDTH-1:0] im,
    output logic                        out_valid,
    output logic [TAG_W-1:0]            out_tag,
    output logic [2*BIT_WIDTH-1:0]      mag
);

    localparam int SQ_W = 2 * BIT_WIDTH - 1;

    logic signed [2*BIT_WIDTH-1:0] re_ext;
    logic signed [2*BIT_WIDTH-1:0] im_ext;
    logic [SQ_W-1:0]               re_sq;
    logic [SQ_W-1:0]               im_sq;
    logic                          s1_valid;
    logic [TAG_W-1:0]              s1_tag;

    assign re_ext = {{BIT_WIDTH{re[BIT_WIDTH-1]}}, re};
    assign im_ext = {{BIT_WIDTH{im[BIT_WIDTH-1]}}, im};

    // Squares are never negative and peak at 2^(2*BIT_WIDTH-2), so the sign bit is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_tag    <= '0;
            re_sq     <= '0;
            im_sq     <= '0;
            out_valid <= 1'b0;
            out_tag   <= '0;
            mag       <= '0;
        end else begin
            s1_valid  <= in_valid && !flush;
            s1_tag    <= in_tag;
            re_sq     <= SQ_W'(re_ext * re_ext);
            im_sq     <= SQ_W'(im_ext * im_ext);
            out_valid <= s1_valid && !flush;
            out_tag   <= s1_tag;
            mag       <= {1'b0, re_sq} + {1'b0, im_sq};
        end
    end

endmodule

// File: rtl/fft_peak_detect.sv
// Peak search over FFT bins 1..FFT_SIZE/2-1 during the output phase.
// Optional PEAK_NEIGHBOR_EN adds the magnitudes of the bins on either side of the peak.
module fft_peak_detect
    import fft_peak_detect_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9,
    parameter int FFT_SIZE  = 512
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fft_start,
    input  logic                        fft_done,
    input  logic signed [BIT_WIDTH-1:0] rd_re,
    input  logic signed [BIT_WIDTH-1:0] rd_im,
    input  logic [2*BIT_WIDTH-1:0]      threshold,
    output logic [N-2:0]                peak_bin,
    output logic [2*BIT_WIDTH-1:0]      peak_mag,
    output logic                        note_present,
    output logic                        peak_valid,
    output logic                        scan_err
`ifdef PEAK_NEIGHBOR_EN
    ,
    output logic [2*BIT_WIDTH-1:0]      nb_lo_mag,
    output logic [2*BIT_WIDTH-1:0]      nb_hi_mag
`endif
);

    localparam int MW   = 2 * BIT_WIDTH;
    localparam int HALF = FFT_SIZE / 2;
`ifdef PEAK_NEIGHBOR_EN
    localparam int LAST = HALF;
`else
    localparam int LAST = HALF - 1;
`endif
    localparam logic [N-1:0] LAST_BIN = N'(LAST);
    localparam logic [N-1:0] TOP_BIN  = N'(HALF - 1);

    state_t          state;
    logic [N-1:0]    cnt;
    logic            a_valid;
    logic [N-1:0]    a_bin;
    logic            m_valid;
    logic [N-1:0]    m_bin;
    logic [MW-1:0]   m_mag;
    logic [MW-1:0]   best_mag;
    logic [N-2:0]    best_bin;
    logic [MW-1:0]   nxt_mag;
    logic [N-2:0]    nxt_bin;
    logic            pulse_q;
    logic            feed;
    logic            abort;
    logic            flush;
    logic            active;
    logic            last;
    logic            upd;
`ifdef PEAK_NEIGHBOR_EN
    logic [MW-1:0]   prev_mag;
    logic [MW-1:0]   best_lo;
    logic [MW-1:0]   best_hi;
    logic            pend;
    logic [MW-1:0]   nxt_lo;
    logic [MW-1:0]   nxt_hi;
    logic            nxt_pend;
`endif

    assign feed   = !fft_start && fft_done && (state == IDLE || state == SCAN);
    assign abort  = !fft_start && (state == SCAN) && !fft_done;
    assign flush  = fft_start || abort;
    assign active = !fft_start && m_valid && (state == SCAN || state == DRAIN);
    assign last   = active && (m_bin == LAST_BIN);

    // fft_start must be able to kill a pulse already sitting in the output register.
    assign peak_valid = pulse_q && !fft_start;

    mag_sq #(
        .BIT_WIDTH (BIT_WIDTH),
        .TAG_W     (N)
    ) u_mag_sq (
        .clk       (clk),
        .rst       (reset),
        .flush     (flush),
        .in_valid  (a_valid),
        .in_tag    (a_bin),
        .re        (rd_re),
        .im        (rd_im),
        .out_valid (m_valid),
        .out_tag   (m_bin),
        .mag       (m_mag)
    );

    always_comb begin
        upd     = active && (m_bin != '0) && (m_bin <= TOP_BIN) && (m_mag > best_mag);
        nxt_mag = upd ? m_mag : best_mag;
        nxt_bin = upd ? m_bin[N-2:0] : best_bin;
`ifdef PEAK_NEIGHBOR_EN
        nxt_lo   = best_lo;
        nxt_hi   = best_hi;
        nxt_pend = pend;
        if (active && pend) begin
            nxt_hi   = m_mag;
            nxt_pend = 1'b0;
        end
        if (upd) begin
            nxt_lo   = prev_mag;
            nxt_pend = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            a_valid      <= 1'b0;
            a_bin        <= '0;
            best_mag     <= '0;
            best_bin     <= '0;
            pulse_q      <= 1'b0;
            scan_err     <= 1'b0;
            peak_bin     <= '0;
            peak_mag     <= '0;
            note_present <= 1'b0;
`ifdef PEAK_NEIGHBOR_EN
            prev_mag     <= '0;
            best_lo      <= '0;
            best_hi      <= '0;
            pend         <= 1'b0;
            nb_lo_mag    <= '0;
            nb_hi_mag    <= '0;
`endif
        end else begin
            a_valid <= feed;
            a_bin   <= (state == IDLE) ? '0 : cnt;
            if (fft_start) begin
                state    <= IDLE;
                scan_err <= 1'b0;
                pulse_q  <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                case (state)
                    IDLE: if (fft_done) begin
                        state    <= SCAN;
                        cnt      <= N'(1);
                        best_mag <= '0;
                        best_bin <= '0;
`ifdef PEAK_NEIGHBOR_EN
                        best_lo  <= '0;
                        best_hi  <= '0;
                        pend     <= 1'b0;
`endif
                    end
                    SCAN: if (!fft_done) begin
                        state    <= IDLE;
                        scan_err <= 1'b1;
                    end else begin
                        cnt <= cnt + N'(1);
                        if (cnt == LAST_BIN) state <= DRAIN;
                    end
                    DRAIN: if (last) begin
                        state        <= DONE;
                        pulse_q      <= 1'b1;
                        peak_bin     <= nxt_bin;
                        peak_mag     <= nxt_mag;
                        note_present <= (nxt_mag >= threshold);
`ifdef PEAK_NEIGHBOR_EN
                        nb_lo_mag    <= nxt_lo;
                        nb_hi_mag    <= nxt_hi;
`endif
                    end
                    DONE:    state <= WAIT;
                    WAIT:    if (!fft_done) state <= IDLE;
                    default: state <= IDLE;
                endcase
                if (active) begin
                    best_mag <= nxt_mag;
                    best_bin <= nxt_bin;
`ifdef PEAK_NEIGHBOR_EN
                    prev_mag <= m_mag;
                    best_lo  <= nxt_lo;
                    best_hi  <= nxt_hi;
                    pend     <= nxt_pend;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed self-checking bench for fft_peak_detect; covers PEAK_NEIGHBOR_EN when that macro is defined.
module tb_fft_peak_detect;
    import fft_peak_detect_pkg::*;

`ifdef PEAK_NEIGHBOR_EN
    localparam int PV_CYC = 260;
`else
    localparam int PV_CYC = 259;
`endif
    localparam mag_t BIG = 32'h8000_0000;

    logic               clk = 1'b0;
    logic               reset;
    logic               fft_start;
    logic               fft_done;
    logic signed [15:0] rd_re;
    logic signed [15:0] rd_im;
    logic [31:0]        threshold;
    logic [7:0]         peak_bin;
    logic [31:0]        peak_mag;
    logic               note_present;
    logic               peak_valid;
    logic               scan_err;
`ifdef PEAK_NEIGHBOR_EN
    logic [31:0]        nb_lo_mag;
    logic [31:0]        nb_hi_mag;
`endif

    logic signed [15:0] re_mem [512];
    logic signed [15:0] im_mem [512];
    int                 n_checks = 0;
    int                 n_pass   = 0;
    int                 pv_count;
    int                 pv_cycle;

    always #5 clk = ~clk;

    fft_peak_detect #(
        .BIT_WIDTH (16),
        .N         (9),
        .FFT_SIZE  (512)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fft_start    (fft_start),
        .fft_done     (fft_done),
        .rd_re        (rd_re),
        .rd_im        (rd_im),
        .threshold    (threshold),
        .peak_bin     (peak_bin),
        .peak_mag     (peak_mag),
        .note_present (note_present),
        .peak_valid   (peak_valid),
        .scan_err     (scan_err)
`ifdef PEAK_NEIGHBOR_EN
        ,
        .nb_lo_mag    (nb_lo_mag),
        .nb_hi_mag    (nb_hi_mag)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) begin
            re_mem[i] = '0;
            im_mem[i] = '0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        fft_start = 1'b1;
        @(negedge clk);
        fft_start = 1'b0;
    endtask

    task automatic check_zero_outputs(input string pfx);
        check({pfx, "_bin"},  64'(peak_bin),     64'd0);
        check({pfx, "_mag"},  64'(peak_mag),     64'd0);
        check({pfx, "_note"}, 64'(note_present), 64'd0);
        check({pfx, "_pv"},   64'(peak_valid),   64'd0);
        check({pfx, "_err"},  64'(scan_err),     64'd0);
    endtask

    // Cycle c: fft_done high for c < len, data of address cycle c-1 presented in cycle c.
    task automatic run_frame(input int len, input int rst_at);
        pv_count = 0;
        pv_cycle = -1;
        for (int c = 0; c < len + 10; c++) begin
            @(negedge clk);
            if (peak_valid) begin
                pv_count++;
                pv_cycle = c;
            end
            if (c == rst_at) begin
                reset    = 1'b1;
                fft_done = 1'b0;
                #1;
                check_zero_outputs("rst_mid");
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            fft_done = (c < len);
            rd_re    = (c >= 1 && c <= len) ? re_mem[c-1] : '0;
            rd_im    = (c >= 1 && c <= len) ? im_mem[c-1] : '0;
        end
    endtask

    initial begin
        reset     = 1'b1;
        fft_start = 1'b0;
        fft_done  = 1'b0;
        rd_re     = '0;
        rd_im     = '0;
        threshold = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;

        // Single tone at 37; a larger upper-half bin must be ignored.
        re_mem[37]  = 16'sd1000;
        re_mem[300] = 16'sd2000;
        threshold   = 32'd1000000;
        pulse_start();
        run_frame(512, -1);
        check("tone_pv_count", 64'(pv_count), 64'd1);
        check("tone_pv_cycle", 64'(pv_cycle), 64'(PV_CYC));
        check("tone_bin",      64'(peak_bin), 64'd37);
        check("tone_mag",      64'(peak_mag), 64'd1000000);
        check("tone_note",     64'(note_present), 64'd1);
        check("tone_err",      64'(scan_err), 64'd0);

        // DC excluded, equal bins 10 and 20: lowest wins.
        clear_mem();
        re_mem[0]  = 16'sd30000;
        im_mem[10] = -16'sd500;
        im_mem[20] = -16'sd500;
        threshold  = 32'd250000;
        pulse_start();
        run_frame(512, -1);
        check("tie_pv_count", 64'(pv_count), 64'd1);
        check("tie_bin",      64'(peak_bin), 64'd10);
        check("tie_mag",      64'(peak_mag), 64'd250000);
        check("thr_eq_note",  64'(note_present), 64'd1);

        threshold = 32'd250001;
        pulse_start();
        run_frame(512, -1);
        check("thr_gt_mag",  64'(peak_mag), 64'd250000);
        check("thr_gt_note", 64'(note_present), 64'd0);

        // Early abort after 100 address cycles.
        pulse_start();
        run_frame(100, -1);
        check("abort_err",      64'(scan_err), 64'd1);
        check("abort_pv_count", 64'(pv_count), 64'd0);
        check("abort_bin",      64'(peak_bin), 64'd10);
        check("abort_mag",      64'(peak_mag), 64'd250000);
        pulse_start();
        check("start_clr_err",  64'(scan_err), 64'd0);
        check("start_keep_bin", 64'(peak_bin), 64'd10);

        // Full-scale sample at the last searched bin.
        clear_mem();
        re_mem[255] = -16'sd32768;
        im_mem[255] = -16'sd32768;
        re_mem[300] = -16'sd32768;
        im_mem[300] = -16'sd32768;
        im_mem[254] = 16'sd7;
        re_mem[256] = 16'sd3;
        im_mem[256] = 16'sd4;
        threshold   = 32'd0;
        pulse_start();
        run_frame(512, -1);
        check("ext_pv_cycle", 64'(pv_cycle), 64'(PV_CYC));
        check("ext_bin",      64'(peak_bin), 64'd255);
        check("ext_mag",      64'(peak_mag), 64'(BIG));
`ifdef PEAK_NEIGHBOR_EN
        check("ext_nb_lo",    64'(nb_lo_mag), 64'd49);
        check("ext_nb_hi",    64'(nb_hi_mag), 64'd25);
`endif

        // Reset in the middle of a scan, then a clean frame.
        clear_mem();
        re_mem[37] = 16'sd1000;
        pulse_start();
        run_frame(512, 50);
        run_frame(512, -1);
        check("post_rst_pv_count", 64'(pv_count), 64'd1);
        check("post_rst_bin",      64'(peak_bin), 64'd37);
        check("post_rst_mag",      64'(peak_mag), 64'd1000000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
